// File: rtl/imem_loader.sv
// imem_loader: fills a writable instruction memory from a host byte stream
// and holds the CPU in reset until a complete, checksummed image is in place.
//
// Stream format: length byte N (1..DEPTH), N data bytes, one checksum byte
// equal to the 8-bit sum of the data bytes.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   in_valid   host byte valid
//   in_data    host byte
//   in_ready   loader accepts a byte this cycle
//   im_wr      instruction memory write strobe (one cycle per word)
//   im_abus    instruction memory write address
//   im_dbus    instruction memory write data
//   cpu_reset  CPU reset, high unless the image is loaded and verified
//   done       image loaded and verified, CPU running
//   err        load failed (bad length or checksum)
//   word_cnt   number of words written so far
//
// state  | meaning
// -------+-----------------------------------------------
// LEN    | waiting for the length byte
// DATA   | writing data bytes, one memory word per byte
// CSUM   | waiting for the checksum byte
// RUN    | image verified, CPU released; terminal until reset
// ERROR  | bad length or checksum, CPU held; terminal until reset

module imem_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              im_wr,
    output logic [ADDR_W-1:0] im_abus,
    output logic [DATA_W-1:0] im_dbus,
    output logic              cpu_reset,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_cnt
);

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_CSUM  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [DATA_W-1:0] DEPTH_V = DATA_W'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   rem_q, rem_d;      // data bytes still expected
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] abus_q, abus_d;
    logic [DATA_W-1:0] dbus_q, dbus_d;
    logic              accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LEN;
            rem_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            wr_q    <= 1'b0;
            abus_q  <= '0;
            dbus_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            wr_q    <= wr_d;
            abus_q  <= abus_d;
            dbus_q  <= dbus_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        wr_d    = 1'b0;
        abus_d  = abus_q;
        dbus_d  = dbus_q;

        in_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
        accept   = in_valid && in_ready;

        case (state_q)
            ST_LEN: begin
                if (accept) begin
                    if ((in_data != '0) && (in_data <= DEPTH_V)) begin
                        rem_d   = in_data[ADDR_W:0];
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    wr_d   = 1'b1;
                    abus_d = cnt_q[ADDR_W-1:0];
                    dbus_d = in_data;
                    cnt_d  = cnt_q + 1'b1;
                    sum_d  = sum_q + in_data;
                    rem_d  = rem_q - 1'b1;
                    // terminal count: this byte was the last one
                    if (rem_q == {{ADDR_W{1'b0}}, 1'b1}) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    state_d = (in_data == sum_q) ? ST_RUN : ST_ERROR;
                end
            end
            ST_RUN:   state_d = ST_RUN;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    assign im_wr     = wr_q;
    assign im_abus   = abus_q;
    assign im_dbus   = dbus_q;
    assign word_cnt  = cnt_q;
    assign done      = (state_q == ST_RUN);
    assign err       = (state_q == ST_ERROR);
    assign cpu_reset = (state_q != ST_RUN);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface: the CPU only reads instruction memory; this block fills it.
- Takes a byte stream from a host over a valid/ready handshake and writes it word by word into a writable instruction memory on the im_abus/im_dbus bus.
- Holds the CPU in reset while loading. Releases it only after a complete image with a correct checksum has been written.

Parameters:
- ADDR_W, 5, instruction memory address width.
- DATA_W, 8, instruction word width (equal to the stream byte width).
- DEPTH, 32, number of instruction words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader can accept a byte this cycle.
- im_wr  output  1  instruction memory write strobe, one-cycle pulse per word.
- im_abus  output  ADDR_W  instruction memory write address.
- im_dbus  output  DATA_W  instruction memory write data.
- cpu_reset  output  1  reset to the CPU; 1 while loading or in error.
- done  output  1  image loaded and verified; CPU running.
- err  output  1  load failed (bad length or checksum).
- word_cnt  output  ADDR_W+1  number of words written so far.

Behaviour:
- Reset (reset=1 at an edge): state=LEN, in_ready=1, im_wr=0, im_abus=0, im_dbus=0, cpu_reset=1, done=0, err=0, word_cnt=0, internal sum=0.
- Reset applied mid-load or mid-run does the same. Memory words already written are not cleared.
- A byte is accepted at an edge when in_valid=1 and in_ready=1. in_data is ignored when in_valid=0. A byte may be accepted every cycle (no bubbles required).
- Stream format: length byte N, then N data bytes, then 1 checksum byte.
- Checksum rule: the checksum byte must equal the 8-bit sum (mod 256) of the N data bytes.
- State LEN:
  - On accept, if 1 <= N <= DEPTH: store N, go to DATA.
  - If N = 0 or N > DEPTH: go to ERROR.
- State DATA:
  - On accept of the k-th data byte (k = 0..N-1), in the next cycle: im_wr=1, im_abus=k, im_dbus=byte.
  - On that same accept edge: word_cnt increments and sum += byte, truncated to 8 bits.
  - im_wr is high for exactly one cycle per accepted byte and 0 otherwise. im_abus and im_dbus hold their last values when im_wr=0.
  - After the N-th byte is accepted, go to CSUM.
  - The address never wraps, because N <= DEPTH.
- State CSUM:
  - On accept, if the byte equals sum: go to RUN.
  - Otherwise: go to ERROR.
- State RUN: in_ready=0, cpu_reset=0, done=1. Registered outputs change in the cycle after the checksum accept. Stays in RUN until reset.
- State ERROR: in_ready=0, cpu_reset=1, err=1, done=0, im_wr=0. Stays in ERROR until reset.
- The final data write pulse (cycle after the N-th accept) may coincide with the checksum accept. Both take effect.
- cpu_reset is never 0 in any state other than RUN.
- done and err are never both 1.

Test Plan:
- Nominal load: reset, then stream 03, 11, 22, 33, 66.
  - Expect im_wr pulses at addresses 0/1/2 with data 11/22/33.
  - Expect word_cnt=3.
  - Expect the cycle after checksum accept: cpu_reset=0, done=1, in_ready=0.
- Checksum wrap: stream 02, F0, 20, 10 (F0+20=0x110, truncated to 10).
  - Expect RUN, done=1.
  - Repeat with checksum 11: expect ERROR, err=1, cpu_reset=1.
- Bad length:
  - Length 00 → ERROR after 1 accept, no im_wr pulse.
  - Length 21 (33) → same result.
- Full depth: length 20 (32), bytes 00..1F, checksum F0.
  - Expect 32 writes to addresses 0..31, word_cnt=32, done=1.
- Back-to-back and gaps:
  - in_valid held high continuously → one write per cycle.
  - in_valid toggling 1/0 → no write in cycles without an accept.
  - Holding in_valid in RUN → nothing accepted.
- Reset mid-load: assert reset after 2 of 4 data bytes.
  - Expect all outputs back to reset values.
  - A fresh 01, AA, AA stream then reaches done=1 with a single write to address 0.
